// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the two-port data-memory arbiter.
// Directions are named from the arbiter's point of view (slave modport).
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [31:0]   cpu_wdata_i;
  logic          cpu_ack_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [31:0]   dbg_wdata_i;
  logic          dbg_ack_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          mem_we_o;
  logic          mem_re_o;
  logic [31:0]   mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  mem_rdata_i,
    output cpu_ack_o, dbg_ack_o, rdata_o, err_o,
    output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output mem_rdata_i,
    input  cpu_ack_o, dbg_ack_o, rdata_o, err_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / debug) arbiter in front of a single-port data memory, 3-cycle transactions.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise CPU has priority.
module dmem_arbiter #(
  parameter int DEPTH = 128,
  parameter int AW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH * 4);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_dbg;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic          w_any_req;
  logic          w_pick_dbg;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;

  assign w_any_req = bus.cpu_req_i || bus.dbg_req_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last_dbg;
  // On a tie the grant goes to whichever requester did not win last time.
  assign w_pick_dbg = bus.dbg_req_i && (!bus.cpu_req_i || !r_last_dbg);
`else
  assign w_pick_dbg = bus.dbg_req_i && !bus.cpu_req_i;
`endif

  assign w_we    = w_pick_dbg ? bus.dbg_we_i    : bus.cpu_we_i;
  assign w_addr  = w_pick_dbg ? bus.dbg_addr_i  : bus.cpu_addr_i;
  assign w_wdata = w_pick_dbg ? bus.dbg_wdata_i : bus.cpu_wdata_i;
  assign w_err   = (w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= LIMIT);

  assign bus.rdata_o = r_rdata;

  always_comb begin
    w_state_nxt     = r_state;
    bus.cpu_ack_o   = 1'b0;
    bus.dbg_ack_o   = 1'b0;
    bus.err_o       = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_re_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        w_state_nxt = RESP;
        // An erroneous command never reaches the memory.
        if (!r_err) begin
          bus.mem_addr_o  = r_addr;
          bus.mem_wdata_o = r_wdata;
          bus.mem_we_o    = r_we;
          bus.mem_re_o    = !r_we;
        end
      end
      RESP: begin
        w_state_nxt   = IDLE;
        bus.cpu_ack_o = !r_dbg;
        bus.dbg_ack_o = r_dbg;
        bus.err_o     = r_err;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_dbg   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      r_last_dbg <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any_req) begin
        r_dbg   <= w_pick_dbg;
        r_we    <= w_we;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_err   <= w_err;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        r_last_dbg <= w_pick_dbg;
`endif
      end
      // Reads capture memory data; errors clear the result; good writes leave it untouched.
      if (r_state == ACCESS) begin
        if (r_err)      r_rdata <= '0;
        else if (!r_we) r_rdata <= bus.mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   we_cnt = 0;
  int   re_cnt = 0;
  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32)) bus ();

  dmem_arbiter #(.DEPTH(128), .AW(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we_o) mem[bus.mem_addr_o[8:2]] <= bus.mem_wdata_o;
    if (bus.mem_we_o) we_cnt <= we_cnt + 1;
    if (bus.mem_re_o) re_cnt <= re_cnt + 1;
  end
  assign bus.mem_rdata_i = mem[bus.mem_addr_o[8:2]];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input logic dbg, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int we0;
    int re0;
    if (dbg) begin
      bus.dbg_req_i = 1'b1; bus.dbg_we_i = we; bus.dbg_addr_i = addr; bus.dbg_wdata_i = wdata;
    end else begin
      bus.cpu_req_i = 1'b1; bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wdata;
    end
    we0 = we_cnt;
    re0 = re_cnt;
    tick();
    chk1 ({tag, ":access_we"},   bus.mem_we_o, we && !exp_err);
    chk1 ({tag, ":access_re"},   bus.mem_re_o, !we && !exp_err);
    chk32({tag, ":access_addr"}, bus.mem_addr_o, exp_err ? 32'h0 : addr);
    if (we && !exp_err) chk32({tag, ":access_wdata"}, bus.mem_wdata_o, wdata);
    chk1 ({tag, ":no_early_ack"}, bus.cpu_ack_o | bus.dbg_ack_o, 1'b0);
    tick();
    chk1 ({tag, ":cpu_ack"},    bus.cpu_ack_o, !dbg);
    chk1 ({tag, ":dbg_ack"},    bus.dbg_ack_o, dbg);
    chk1 ({tag, ":err"},        bus.err_o, exp_err);
    chk32({tag, ":rdata"},      bus.rdata_o, exp_rdata);
    chk1 ({tag, ":resp_strobe"}, bus.mem_we_o | bus.mem_re_o, 1'b0);
    bus.cpu_req_i = 1'b0;
    bus.dbg_req_i = 1'b0;
    tick();
    chk1 ({tag, ":idle_ack"},   bus.cpu_ack_o | bus.dbg_ack_o | bus.err_o, 1'b0);
    chk32({tag, ":rdata_hold"}, bus.rdata_o, exp_rdata);
    chk32({tag, ":we_pulses"},  32'(we_cnt - we0), {31'b0, we && !exp_err});
    chk32({tag, ":re_pulses"},  32'(re_cnt - re0), {31'b0, !we && !exp_err});
  endtask

  initial begin
    logic exp_c;
    logic exp_d;
    rst_n = 1'b0;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
    repeat (3) tick();
    chk1 ("rst:cpu_ack", bus.cpu_ack_o, 1'b0);
    chk1 ("rst:dbg_ack", bus.dbg_ack_o, 1'b0);
    chk1 ("rst:err",     bus.err_o, 1'b0);
    chk1 ("rst:mem_we",  bus.mem_we_o, 1'b0);
    chk1 ("rst:mem_re",  bus.mem_re_o, 1'b0);
    chk32("rst:rdata",   bus.rdata_o, 32'h0);
    chk32("rst:addr",    bus.mem_addr_o, 32'h0);
    chk32("rst:wdata",   bus.mem_wdata_o, 32'h0);

    // Requests while reset is held must do nothing.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h10; bus.cpu_wdata_i = 32'hDEAD;
    repeat (3) begin
      tick();
      chk1("rst_held:mem_we", bus.mem_we_o, 1'b0);
      chk1("rst_held:ack",    bus.cpu_ack_o, 1'b0);
    end
    bus.cpu_req_i = 1'b0;
    rst_n = 1'b1;
    tick();

    xact("cpu_wr10",  1'b0, 1'b1, 32'h10,  32'd25,        1'b0, 32'h0);
    xact("cpu_rd10",  1'b0, 1'b0, 32'h10,  32'h0,         1'b0, 32'd25);
    xact("dbg_wr20",  1'b1, 1'b1, 32'h20,  32'hA5A5_0001, 1'b0, 32'd25);
    xact("dbg_rd20",  1'b1, 1'b0, 32'h20,  32'h0,         1'b0, 32'hA5A5_0001);
    xact("cpu_wr202", 1'b0, 1'b1, 32'h202, 32'h1234,      1'b1, 32'h0);
    xact("cpu_rd10b", 1'b0, 1'b0, 32'h10,  32'h0,         1'b0, 32'd25);
    xact("dbg_rd200", 1'b1, 1'b0, 32'h200, 32'h0,         1'b1, 32'h0);
    xact("cpu_wr1fc", 1'b0, 1'b1, 32'h1FC, 32'd7,         1'b0, 32'h0);
    xact("cpu_rd1fc", 1'b0, 1'b0, 32'h1FC, 32'h0,         1'b0, 32'd7);

    // Reset landing in the ACCESS cycle of a write.
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h30; bus.cpu_wdata_i = 32'd99;
    tick();
    chk1("rstacc:we_before", bus.mem_we_o, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1 ("rstacc:mem_we", bus.mem_we_o, 1'b0);
    chk1 ("rstacc:mem_re", bus.mem_re_o, 1'b0);
    chk1 ("rstacc:ack",    bus.cpu_ack_o, 1'b0);
    chk1 ("rstacc:err",    bus.err_o, 1'b0);
    chk32("rstacc:rdata",  bus.rdata_o, 32'h0);
    bus.cpu_req_i = 1'b0;
    rst_n = 1'b1;
    tick();
    chk1("rstacc:no_late_ack", bus.cpu_ack_o, 1'b0);
    xact("post_rst_rd", 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'd25);

    // Simultaneous reads straight out of reset, both requests held.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h10;
    bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = 32'h20;
    for (int k = 1; k <= 9; k++) begin
      tick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      exp_c = (k % 3 == 2) && ((k / 3) % 2 == 0);
      exp_d = (k % 3 == 2) && ((k / 3) % 2 == 1);
`else
      exp_c = (k % 3 == 2);
      exp_d = 1'b0;
`endif
      chk1($sformatf("sim:cpu_ack_k%0d", k), bus.cpu_ack_o, exp_c);
      chk1($sformatf("sim:dbg_ack_k%0d", k), bus.dbg_ack_o, exp_d);
      if (exp_c) chk32($sformatf("sim:cpu_rdata_k%0d", k), bus.rdata_o, 32'd25);
      if (exp_d) chk32($sformatf("sim:dbg_rdata_k%0d", k), bus.rdata_o, 32'hA5A5_0001);
    end
    bus.cpu_req_i = 1'b0;
    bus.dbg_req_i = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, number of 32-bit words in the shared data memory.
REQ-002 Parameter AW, default 32, width of requester byte addresses.
REQ-003 Ports, clock and reset first:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- cpu_req_i  in  1  CPU access request.
- cpu_we_i  in  1  CPU write (1) / read (0).
- cpu_addr_i  in  AW  CPU byte address.
- cpu_wdata_i  in  32  CPU write data.
- cpu_ack_o  out  1  CPU transaction complete, one-cycle pulse.
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ack_o  same widths as the CPU ports; debug/loader requester.
- rdata_o  out  32  read data for the acked requester; valid in the ack cycle.
- err_o  out  1  access error, pulsed together with the ack.
- mem_addr_o  out  AW  byte address to the data memory.
- mem_wdata_o  out  32  write data to the data memory.
- mem_we_o  out  1  memory write strobe.
- mem_re_o  out  1  memory read strobe.
- mem_rdata_i  in  32  combinational read data from the memory.
REQ-004 Clock and reset are one clock, clk_i, and a synchronous active-low reset, rst_i.

Function
REQ-005 The FSM has three states: IDLE, ACCESS and RESP. Transitions are IDLE->ACCESS when any request is high, ACCESS->RESP, and RESP->IDLE.
REQ-006 In IDLE the block shall pick a winner and latch its we, addr and wdata. A requester shall hold its command stable from req until ack.
REQ-007 In ACCESS the block shall drive the latched command for exactly one cycle. mem_we_o is high for writes and mem_re_o is high for reads; only one of the two is ever high.
REQ-008 On a read, mem_rdata_i shall be registered at the end of ACCESS. rdata_o holds that value during RESP.
REQ-009 In RESP, the winner's ack shall be high for one cycle. Requests are ignored in RESP.
REQ-010 Latency is fixed: a request sampled in IDLE at edge N gives ack high during cycle N+2. The maximum rate is one transaction per 3 cycles.
REQ-011 A req still high in IDLE after its ack shall be treated as a new transaction.
REQ-012 Outside ACCESS, mem_we_o and mem_re_o shall be 0 and mem_addr_o/mem_wdata_o shall be 0.
REQ-013 Outside RESP, rdata_o shall hold its last value. It is 0 after reset.
REQ-014 If the latched addr[1:0] != 0, or addr >= DEPTH*4, the access is an error:
- no mem_we_o or mem_re_o pulse is issued;
- err_o pulses with the ack;
- rdata_o is 0.
REQ-015 A write reports rdata_o unchanged from its prior value.

Reset
REQ-016 When rst_i=0 at an edge, the block shall:
- go to IDLE;
- reset last_grant to DBG;
- set all outputs to 0;
- drop any latched command.
REQ-017 A reset asserted during ACCESS or RESP shall drop the transaction. The pending ack and err are never issued, and no memory strobe is high in the cycle after the reset edge.
REQ-018 With rst_i=0 held, request inputs have no effect.

Configuration
REQ-019 With macro DMEM_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE are granted to the requester not in last_grant. last_grant updates on every grant.
REQ-020 Without DMEM_ARB_ROUND_ROBIN_EN, the CPU always wins simultaneous requests; last_grant is then not implemented.
REQ-021 A single requester is granted immediately in either build.

Verification
REQ-022 CPU write addr 0x10, data 25, then CPU read addr 0x10 -> the write gives one mem_we_o pulse with mem_addr_o=0x10; the read acks at N+2 with rdata_o=25 and err_o=0.
REQ-023 Simultaneous CPU and DBG reads out of reset:
- round-robin build -> CPU acked first, then DBG 3 cycles later;
- fixed-priority build with CPU holding req -> DBG is never acked while CPU req is held continuously.
REQ-024 CPU write to addr 0x0000_0202 (misaligned) -> no mem_we_o, err_o=1 with cpu_ack_o, rdata_o=0.
REQ-025 DBG read of addr DEPTH*4 (0x200 at default) -> err_o=1 with dbg_ack_o, no mem_re_o.
REQ-026 rst_i=0 asserted in the ACCESS cycle of a CPU write -> no ack, FSM in IDLE, mem_we_o=0 on the next cycle, and a subsequent request completes normally.
